// File: rtl/sevseg_scan_pkg.sv
// Shared constants and helpers for the seven-segment scan stages.
package sevseg_scan_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  // A code is displayable only if the downstream decoder defines it (0..9).
  function automatic logic bcd_valid(input logic [BCD_W-1:0] code);
    return (code <= BCD_MAX);
  endfunction

endpackage

// File: rtl/sevseg_scan_if.sv
// Host-side load port and decoder/digit-drive outputs of the display scanner.
interface sevseg_scan_if
  import sevseg_scan_pkg::*;
#(
  parameter int NDIG = 4
);

  logic                   LOAD;
  logic [BCD_W*NDIG-1:0]  VAL;
  logic                   BLANK_LZ;
  logic [BCD_W-1:0]       DIG;
  logic                   EN;
  logic [NDIG-1:0]        DSEL;
  logic                   FRAME;

  modport master (
    output LOAD, VAL, BLANK_LZ,
    input  DIG, EN, DSEL, FRAME
  );

  modport slave (
    input  LOAD, VAL, BLANK_LZ,
    output DIG, EN, DSEL, FRAME
  );

endinterface

// File: rtl/sevseg_prescaler.sv
// Free-running divider: TICK is high for one cycle every PRESCALE cycles,
// the first one PRESCALE cycles after reset is released.
module sevseg_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic CLK,
  input  logic RESET,
  output logic TICK
);

  localparam int                CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..PRESCALE-1 and wrap on the tick edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign TICK = (cnt == LAST);

endmodule

// File: rtl/sevseg_scan.sv
// Multiplexed seven-segment scanner: presents one BCD digit per prescaler
// tick with a one-hot digit select, swaps in newly loaded values only at
// frame boundaries, and blanks invalid codes and (optionally) leading zeros.
module sevseg_scan
  import sevseg_scan_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 1000
) (
  input  logic           CLK,
  input  logic           RESET,
  sevseg_scan_if.slave   bus
);

  localparam int               IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int               VAL_W    = BCD_W * NDIG;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  logic             tick;
  // idx is the digit that the next tick will present; it starts at 0 so the
  // first tick after reset shows digit 0 and opens a frame.
  logic [IDX_W-1:0] idx;
  logic [VAL_W-1:0] display;
  logic [VAL_W-1:0] shadow;
  logic             pending;

  logic             commit;
  logic [VAL_W-1:0] src;
  logic [BCD_W-1:0] dig_next;
  logic             en_next;

  sevseg_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .CLK   (CLK),
    .RESET (RESET),
    .TICK  (tick)
  );

  function automatic logic [BCD_W-1:0] digit_at(input logic [VAL_W-1:0] v,
                                                input logic [IDX_W-1:0] k);
    logic [BCD_W-1:0] d;
    d = '0;
    for (int j = 0; j < NDIG; j++) begin
      if (k == IDX_W'(j)) d = v[BCD_W*j +: BCD_W];
    end
    return d;
  endfunction

  // True when digit k and every more significant digit are zero.
  function automatic logic upper_zero(input logic [VAL_W-1:0] v,
                                      input logic [IDX_W-1:0] k);
    logic z;
    z = 1'b1;
    for (int j = 0; j < NDIG; j++) begin
      if ((IDX_W'(j) >= k) && (v[BCD_W*j +: BCD_W] != '0)) z = 1'b0;
    end
    return z;
  endfunction

  // Select the value for the digit about to be shown; on the frame-opening
  // tick a simultaneous LOAD wins over the shadow so it is visible at once.
  always_comb begin
    commit = tick && (idx == '0);
    src    = display;
    if (commit) begin
      if (bus.LOAD)    src = bus.VAL;
      else if (pending) src = shadow;
    end
    dig_next = digit_at(src, idx);
    en_next  = bcd_valid(dig_next) &&
               !(bus.BLANK_LZ && (idx != '0) && upper_zero(src, idx));
  end

  // Scan index, shadow capture and frame-boundary commit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      idx     <= '0;
      display <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      if (tick) idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      if (commit) begin
        display <= src;
        pending <= 1'b0;
      end else if (bus.LOAD) begin
        shadow  <= bus.VAL;
        pending <= 1'b1;
      end
    end
  end

  // Registered display outputs, updated only on ticks; FRAME marks the cycle
  // after the tick that presented digit 0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bus.DIG   <= '0;
      bus.EN    <= 1'b0;
      bus.DSEL  <= '0;
      bus.FRAME <= 1'b0;
    end else begin
      bus.FRAME <= commit;
      if (tick) begin
        bus.DIG  <= dig_next;
        bus.EN   <= en_next;
        bus.DSEL <= NDIG'(1) << idx;
      end
    end
  end

endmodule

// File: tb/tb_sevseg_scan.sv
// Scoreboard bench for sevseg_scan: a frame-level model predicts each digit
// presentation, a monitor pops and compares whenever DSEL moves.
module tb_sevseg_scan;

  localparam int NDIG      = 4;
  localparam int PRESCALE  = 4;
  localparam int FRAME_LEN = NDIG * PRESCALE;

  typedef struct packed {
    logic [3:0]      dig;
    logic            en;
    logic [NDIG-1:0] dsel;
  } exp_t;

  logic CLK;
  logic RESET;

  sevseg_scan_if #(.NDIG(NDIG)) bus ();

  sevseg_scan #(
    .NDIG     (NDIG),
    .PRESCALE (PRESCALE)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  // Model state: edges since reset release, ticks seen, displayed value,
  // most recent uncommitted load.
  int          e = 0;
  int          t = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_shadow = '0;
  bit          m_pend = 0;
  bit          exp_frame = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every PRESCALE edges one digit is presented; the frame
  // start takes the newest requested value (a LOAD on that very edge wins).
  initial begin
    int   k;
    exp_t x;
    logic [15:0] upper;
    forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) begin
        e = 0; t = 0; m_disp = '0; m_shadow = '0; m_pend = 0; exp_frame = 0;
        q.delete();
      end else begin
        e++;
        exp_frame = 0;
        if (e % PRESCALE == 0) begin
          k = t % NDIG;
          t++;
          if (k == 0) begin
            if (bus.LOAD)  m_disp = bus.VAL;
            else if (m_pend) m_disp = m_shadow;
            m_pend    = 0;
            exp_frame = 1;
          end else if (bus.LOAD) begin
            m_shadow = bus.VAL;
            m_pend   = 1;
          end
          upper  = m_disp >> (4 * k);
          x.dig  = upper[3:0];
          x.en   = (x.dig <= 9) && !(bus.BLANK_LZ && k > 0 && upper == 0);
          x.dsel = NDIG'(1 << k);
          q.push_back(x);
        end else if (bus.LOAD) begin
          m_shadow = bus.VAL;
          m_pend   = 1;
        end
      end
    end
  end

  // Monitor: a new DSEL value is a presented digit; it must match the oldest
  // prediction and the previous digit must have been held PRESCALE cycles.
  initial begin
    logic [NDIG-1:0] prev = '0;
    int   hold = 0;
    exp_t x;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        prev = '0;
        hold = 0;
      end else begin
        hold++;
        check("frame", 32'(bus.FRAME), 32'(exp_frame));
        if (bus.DSEL != prev) begin
          if (q.size() == 0) begin
            check("unexpected_dsel", 32'(bus.DSEL), 32'(prev));
          end else begin
            x = q.pop_front();
            check("dsel", 32'(bus.DSEL), 32'(x.dsel));
            check("dig",  32'(bus.DIG),  32'(x.dig));
            check("en",   32'(bus.EN),   32'(x.en));
          end
          check("hold", 32'(hold), 32'(PRESCALE));
          hold = 0;
          prev = bus.DSEL;
        end
      end
    end
  end

  task automatic do_load(input logic [15:0] v);
    bus.LOAD = 1'b1;
    bus.VAL  = v;
    @(negedge CLK);
    bus.LOAD = 1'b0;
  endtask

  // Wait (bounded) until the next rising edge is edge number s within a frame.
  task automatic wait_slot(input int s);
    for (int i = 0; i < 4 * FRAME_LEN; i++) begin
      @(negedge CLK);
      if (((e + 1) % FRAME_LEN) == s) return;
    end
    check("wait_slot_timeout", 32'(e), 32'(s));
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    int nz;
    v = '0;
    for (int i = 0; i < NDIG; i++) begin
      if ($urandom_range(0, 15) >= 13) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else                             v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    nz = $urandom_range(0, 5);
    for (int i = 0; i < NDIG; i++) if (i >= nz) v[4*i +: 4] = 4'h0;
    return v;
  endfunction

  initial begin
    RESET = 1'b1;
    bus.LOAD = 1'b0;
    bus.VAL = '0;
    bus.BLANK_LZ = 1'b0;
    #1;
    check("rst_dsel", 32'(bus.DSEL), 0);
    check("rst_en", 32'(bus.EN), 0);
    repeat (3) @(negedge CLK);
    #1 RESET = 1'b0;

    // Basic value, no blanking; first frame still shows zeros.
    wait_slot(6);
    do_load(16'h1234);
    repeat (3 * FRAME_LEN) @(negedge CLK);

    // Leading-zero blanking.
    bus.BLANK_LZ = 1'b1;
    do_load(16'h0050);
    repeat (2 * FRAME_LEN + 4) @(negedge CLK);
    do_load(16'h0000);
    repeat (2 * FRAME_LEN + 4) @(negedge CLK);

    // Invalid code blanked regardless of BLANK_LZ.
    bus.BLANK_LZ = 1'b0;
    do_load(16'h1A23);
    repeat (2 * FRAME_LEN + 4) @(negedge CLK);
    bus.BLANK_LZ = 1'b1;
    repeat (FRAME_LEN) @(negedge CLK);

    // Mid-frame load while digit 1 is shown, then two loads in one frame.
    bus.BLANK_LZ = 1'b0;
    wait_slot(9);
    do_load(16'h9999);
    repeat (2 * FRAME_LEN) @(negedge CLK);
    wait_slot(6);
    do_load(16'h1111);
    wait_slot(11);
    do_load(16'h2222);
    repeat (2 * FRAME_LEN) @(negedge CLK);

    // Load landing exactly on the commit edge with a pending shadow.
    wait_slot(7);
    do_load(16'h1111);
    wait_slot(4);
    do_load(16'h7777);
    repeat (3 * FRAME_LEN) @(negedge CLK);

    // Random traffic, including BLANK_LZ changes mid-frame.
    for (int i = 0; i < 600; i++) begin
      bus.LOAD = ($urandom_range(0, 7) == 0);
      bus.VAL  = rand_bcd();
      if ($urandom_range(0, 19) == 0) bus.BLANK_LZ = ~bus.BLANK_LZ;
      @(negedge CLK);
    end
    bus.LOAD = 1'b0;

    // Asynchronous reset mid-digit with a pending load that must be dropped.
    wait_slot(10);
    do_load(16'h5555);
    #2 RESET = 1'b1;
    #1;
    check("arst_dsel", 32'(bus.DSEL), 0);
    check("arst_en", 32'(bus.EN), 0);
    check("arst_dig", 32'(bus.DIG), 0);
    check("arst_frame", 32'(bus.FRAME), 0);
    repeat (2) @(negedge CLK);
    #1 RESET = 1'b0;
    bus.BLANK_LZ = 1'b1;
    repeat (2 * FRAME_LEN + 2) @(negedge CLK);

    #1;
    check("drain", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sevseg_scan.md
Name: sevseg_scan

Overview:
- Multiplexed-display scanner that sits directly upstream of the seven-segment decoder.
- Holds an NDIG-digit packed BCD value and time-multiplexes it one digit at a time onto a 4-bit digit bus plus a decoder enable.
- Drives a one-hot digit-select bus for the common anodes/cathodes.
- Provides tear-free value updates at frame boundaries and optional leading-zero blanking.

Parameters:
- NDIG, 4, number of digits scanned (2..8).
- PRESCALE, 1000, CLK cycles each digit is held (>=2).

Ports:
- CLK  input  1  system clock, rising-edge.
- RESET  input  1  asynchronous, active-high reset.
- LOAD  input  1  single-cycle strobe; capture VAL into the shadow register.
- VAL  input  4*NDIG  packed BCD value; digit i is VAL[4i+3:4i], digit 0 is least significant.
- BLANK_LZ  input  1  when 1, blank leading zero digits.
- DIG  output  4  BCD code for the currently selected digit; feeds the decoder DIG input.
- EN  output  1  decoder enable; 0 blanks the current digit.
- DSEL  output  NDIG  one-hot active-high digit select.
- FRAME  output  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Clock and reset: single clock CLK. RESET is asynchronous and active-high.
- Reset values: all outputs 0 (DIG=0, EN=0, DSEL=0, FRAME=0). Prescale counter=0, digit index=0, display register=0, shadow=0, pending=0.
- Prescaler:
  - Counter runs 0..PRESCALE-1.
  - TICK is asserted in the cycle the counter equals PRESCALE-1; the counter wraps to 0 on that edge.
  - The first TICK occurs PRESCALE cycles after RESET deasserts.
- Scan:
  - On each TICK edge the index advances idx -> idx+1, wrapping NDIG-1 -> 0. The index is 0 at the first TICK after reset, then increments.
  - All outputs are registered and change only on TICK edges, except FRAME.
  - Each output triple (DIG, EN, DSEL) is held for exactly PRESCALE cycles.
- Output per TICK edge for new index k:
  - DSEL = 1<<k.
  - DIG = display[4k+3:4k].
  - EN = 1 unless digit k is blanked.
- Blanking rules:
  - A digit whose code is >9 is always blanked (EN=0). The decoder output for 10..15 is undefined, so it must never be enabled with those codes.
  - With BLANK_LZ=1, digit k (k>0) is blanked if it and every digit above it are 0.
  - Digit 0 is never leading-zero blanked, so value 0 displays "0".
  - BLANK_LZ is sampled on each TICK edge; a change mid-frame affects subsequent digits only.
- FRAME: asserted for one cycle following the TICK edge on which the index becomes 0.
- Load handshake:
  - LOAD=1 on an edge copies VAL to the shadow register and sets pending.
  - A LOAD while pending is already set overwrites the shadow; last value wins.
- Commit:
  - On the TICK edge that moves the index to 0, if pending, display <= shadow and pending clears. Digit 0 of the new frame already shows the new value.
  - The display register never changes mid-frame.
- Simultaneous LOAD and commit edge: VAL bypasses the shadow and is committed directly to display (and used for digit 0 output). Pending ends cleared.
- Reset mid-operation: immediate return to reset values; any pending load is discarded.

Decomposition:
- Shared package holds:
  - BCD_W=4 and BCD_MAX=9 constants.
  - A function to test a BCD code for validity.
- One natural sub-module, sevseg_prescaler (parameter PRESCALE; ports CLK, RESET, TICK), reusable for other timed display stages.
- Scan index, shadow/commit and blanking logic stay in sevseg_scan.

Test Plan (NDIG=4, PRESCALE=4):
- Reset, then LOAD VAL=16'h1234, BLANK_LZ=0. The first frame shows 0s (LOAD not yet committed); from the next frame, DSEL sequence 0001,0010,0100,1000 shows DIG 4,3,2,1 with EN=1. Each step is held 4 cycles, and FRAME pulses once per 16 cycles.
- Leading zeros: VAL=16'h0050, BLANK_LZ=1 -> digit0 DIG=0 EN=1; digit1 DIG=5 EN=1; digits 2,3 EN=0. Repeat with VAL=16'h0000 -> only digit0 enabled, DIG=0.
- Invalid code: VAL=16'h1A23 -> digit2 EN=0 regardless of BLANK_LZ; other digits are enabled.
- Mid-frame LOAD: LOAD 16'h9999 while digit1 is shown -> digits 2,3 still show the old value; the new value appears from digit0 of the next frame. Two LOADs in one frame (16'h1111 then 16'h2222) -> only 2222 is displayed.
- LOAD on the commit edge with pending=1 (shadow 16'h1111, VAL=16'h7777) -> digit0 shows 7 immediately and pending ends 0.
- Assert RESET asynchronously mid-digit (no clock edge) -> DSEL=0, EN=0, DIG=0, FRAME=0 at once. After release, the first DSEL=0001 appears 4 cycles later with display=0.
